// File: rtl/instruction_memory_loader.sv
// Instruction memory port owner: byte-serial program loader, then hands the port to fetch.
// Optional running word checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module instruction_memory_loader #(
  parameter int SIZE_EXP2 = 10
) (
  input  logic                 system_clock,
  input  logic                 reset,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [7:0]           load_byte,
  input  logic                 load_last,
  output logic                 load_ready,
  output logic                 load_done,
  output logic                 load_overflow,
  output logic [SIZE_EXP2:0]   load_word_count,
  input  logic [SIZE_EXP2-1:0] fetch_address,
  output logic                 fetch_valid,
  output logic                 cpu_run,
  output logic [SIZE_EXP2-1:0] mem_address,
  output logic                 mem_write_enable,
  output logic [31:0]          mem_write_data,
  output logic [31:0]          load_checksum
);

  localparam logic [SIZE_EXP2-1:0] LAST_ADDR = '1;
  localparam logic [SIZE_EXP2-1:0] ADDR_ONE  = 1;
  localparam logic [SIZE_EXP2:0]   COUNT_ONE = 1;

  typedef enum logic [1:0] {HALT, LOAD, WRITE, RUN} state_t;

  state_t               state;
  logic [SIZE_EXP2-1:0] word_addr;
  logic [SIZE_EXP2-1:0] write_addr;
  logic [1:0]           byte_idx;
  logic [31:0]          assembly;
  logic [31:0]          assembly_next;
  logic                 last_seen;
  logic                 write_strobe;

  always_comb begin
    assembly_next = assembly;
    case (byte_idx)
      2'd0: assembly_next[31:24] = load_byte;
      2'd1: assembly_next[23:16] = load_byte;
      2'd2: assembly_next[15:8]  = load_byte;
      2'd3: assembly_next[7:0]   = load_byte;
      default: assembly_next = assembly;
    endcase
  end

  assign load_ready  = (state == LOAD);
  assign mem_address = fetch_valid ? fetch_address : write_addr;
  // A restart arriving during WRITE must suppress that cycle's strobe.
  assign mem_write_enable = write_strobe & ~load_start;

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state           <= HALT;
      word_addr       <= '0;
      write_addr      <= '0;
      byte_idx        <= '0;
      assembly        <= '0;
      last_seen       <= 1'b0;
      write_strobe    <= 1'b0;
      mem_write_data  <= '0;
      load_word_count <= '0;
      load_done       <= 1'b0;
      load_overflow   <= 1'b0;
      cpu_run         <= 1'b0;
      fetch_valid     <= 1'b0;
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        state           <= LOAD;
        word_addr       <= '0;
        write_addr      <= '0;
        byte_idx        <= '0;
        assembly        <= '0;
        last_seen       <= 1'b0;
        write_strobe    <= 1'b0;
        load_word_count <= '0;
        load_overflow   <= 1'b0;
        cpu_run         <= 1'b0;
        fetch_valid     <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (load_valid) begin
              assembly <= assembly_next;
              if (byte_idx == 2'd3 || load_last) begin
                state          <= WRITE;
                write_strobe   <= 1'b1;
                write_addr     <= word_addr;
                mem_write_data <= assembly_next;
                last_seen      <= load_last;
              end else begin
                byte_idx <= byte_idx + 2'd1;
              end
            end
          end
          WRITE: begin
            write_strobe    <= 1'b0;
            load_word_count <= load_word_count + COUNT_ONE;
            // The top word ends the load; the address is never allowed to wrap.
            if (last_seen || word_addr == LAST_ADDR) begin
              state         <= RUN;
              load_done     <= 1'b1;
              cpu_run       <= 1'b1;
              fetch_valid   <= 1'b1;
              load_overflow <= ~last_seen;
            end else begin
              state     <= LOAD;
              word_addr <= word_addr + ADDR_ONE;
              byte_idx  <= '0;
              assembly  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_sum;

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset)
      checksum_sum <= '0;
    else if (load_start)
      checksum_sum <= '0;
    else if (state == WRITE)
      checksum_sum <= checksum_sum + mem_write_data;
  end

  assign load_checksum = checksum_sum;
`else
  assign load_checksum = '0;
`endif

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Directed bench for instruction_memory_loader with a 4-word memory (SIZE_EXP2=2).
module tb_instruction_memory_loader;
  localparam int AW = 2;

  logic          system_clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic          load_valid = 1'b0;
  logic [7:0]    load_byte = '0;
  logic          load_last = 1'b0;
  logic          load_ready, load_done, load_overflow;
  logic [AW:0]   load_word_count;
  logic [AW-1:0] fetch_address = '0;
  logic          fetch_valid, cpu_run;
  logic [AW-1:0] mem_address;
  logic          mem_write_enable;
  logic [31:0]   mem_write_data, load_checksum;

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [31:0] SUM_TWO_WORDS = 32'hACF1_3568;
`else
  localparam logic [31:0] SUM_TWO_WORDS = 32'h0;
`endif

  instruction_memory_loader #(.SIZE_EXP2(AW)) dut (
    .system_clock(system_clock), .reset(reset), .load_start(load_start),
    .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
    .load_ready(load_ready), .load_done(load_done), .load_overflow(load_overflow),
    .load_word_count(load_word_count), .fetch_address(fetch_address),
    .fetch_valid(fetch_valid), .cpu_run(cpu_run), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .load_checksum(load_checksum)
  );

  always #5 system_clock = ~system_clock;

  always @(posedge system_clock) begin
    if (mem_write_enable) begin
      wa_q.push_back(mem_address);
      wd_q.push_back(mem_write_data);
    end
    if (load_done) done_cnt++;
  end

  task automatic step();
    @(posedge system_clock);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int n = 0;
    load_valid = 1'b1;
    load_byte  = b;
    load_last  = last;
    while (!load_ready && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (!load_ready) begin
      fails++;
      $display("FAIL send_byte_timeout: load_ready=%b required 1", load_ready);
    end else begin
      step();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (!cpu_run && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({load_ready, load_done, load_overflow, cpu_run, fetch_valid, mem_write_enable} !== 6'b0 ||
        mem_address !== '0 || mem_write_data !== '0 || load_word_count !== '0 || load_checksum !== '0) begin
      fails++;
      $display("FAIL reset_values: ctl=%b addr=%h data=%h cnt=%0d sum=%h required all 0",
               {load_ready, load_done, load_overflow, cpu_run, fetch_valid, mem_write_enable},
               mem_address, mem_write_data, load_word_count, load_checksum);
    end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (load_ready !== 1'b0 || cpu_run !== 1'b0) begin
      fails++;
      $display("FAIL halt_idle: ready=%b run=%b required 0 0", load_ready, cpu_run);
    end
  endtask

  task automatic test_two_words();
    int base = wd_q.size();
    int d0 = done_cnt;
    logic [7:0] bytes [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(bytes[i], i == 7);
    wait_run();
    checks++;
    if (cpu_run !== 1'b1 || load_done !== 1'b1) begin
      fails++;
      $display("FAIL two_words_run: run=%b done=%b required 1 1", cpu_run, load_done);
    end
    step();
    checks++;
    if (load_done !== 1'b0 || done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL two_words_done_pulse: done=%b pulses=%0d required 0 and 1", load_done, done_cnt - d0);
    end
    checks++;
    if (wd_q.size() - base != 2) begin
      fails++;
      $display("FAIL two_words_writes: got %0d writes required 2", wd_q.size() - base);
    end else begin
      checks++;
      if (wa_q[base] !== 2'd0 || wd_q[base] !== 32'h1234_5678 ||
          wa_q[base+1] !== 2'd1 || wd_q[base+1] !== 32'h9ABC_DEF0) begin
        fails++;
        $display("FAIL two_words_data: %h@%0d %h@%0d required 12345678@0 9abcdef0@1",
                 wd_q[base], wa_q[base], wd_q[base+1], wa_q[base+1]);
      end
    end
    checks++;
    if (load_word_count !== 3'd2 || load_overflow !== 1'b0 || load_checksum !== SUM_TWO_WORDS) begin
      fails++;
      $display("FAIL two_words_status: cnt=%0d ovf=%b sum=%h required 2 0 %h",
               load_word_count, load_overflow, load_checksum, SUM_TWO_WORDS);
    end
  endtask

  task automatic test_fetch();
    int base = wd_q.size();
    fetch_address = 2'd3;
    #1;
    checks++;
    if (mem_address !== 2'd3 || fetch_valid !== 1'b1 || mem_write_enable !== 1'b0 || load_ready !== 1'b0) begin
      fails++;
      $display("FAIL fetch_passthrough: addr=%h fv=%b we=%b ready=%b required 3 1 0 0",
               mem_address, fetch_valid, mem_write_enable, load_ready);
    end
    fetch_address = 2'd1;
    #1;
    checks++;
    if (mem_address !== 2'd1) begin
      fails++;
      $display("FAIL fetch_follow: addr=%h required 1", mem_address);
    end
    load_valid = 1'b1;
    load_byte  = 8'h55;
    load_last  = 1'b1;
    repeat (3) step();
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch_address = '0;
    checks++;
    if (wd_q.size() != base || cpu_run !== 1'b1) begin
      fails++;
      $display("FAIL run_ignores_bytes: writes=%0d run=%b required 0 1", wd_q.size() - base, cpu_run);
    end
  endtask

  task automatic test_partial_word();
    int base = wd_q.size();
    logic [7:0] bytes [5] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(bytes[i], i == 4);
    wait_run();
    step();
    checks++;
    if (wd_q.size() - base != 2) begin
      fails++;
      $display("FAIL partial_writes: got %0d writes required 2", wd_q.size() - base);
    end else begin
      checks++;
      if (wd_q[base] !== 32'hAABB_CCDD || wa_q[base] !== 2'd0 ||
          wd_q[base+1] !== 32'hEE00_0000 || wa_q[base+1] !== 2'd1) begin
        fails++;
        $display("FAIL partial_data: %h@%0d %h@%0d required aabbccdd@0 ee000000@1",
                 wd_q[base], wa_q[base], wd_q[base+1], wa_q[base+1]);
      end
    end
    checks++;
    if (load_word_count !== 3'd2 || load_overflow !== 1'b0) begin
      fails++;
      $display("FAIL partial_status: cnt=%0d ovf=%b required 2 0", load_word_count, load_overflow);
    end
  endtask

  task automatic test_overflow();
    int base = wd_q.size();
    logic [31:0] exp_words [4] = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'(i + 1), 1'b0);
    wait_run();
    checks++;
    if (cpu_run !== 1'b1 || load_overflow !== 1'b1 || load_word_count !== 3'd4 || load_done !== 1'b1) begin
      fails++;
      $display("FAIL overflow_status: run=%b ovf=%b cnt=%0d done=%b required 1 1 4 1",
               cpu_run, load_overflow, load_word_count, load_done);
    end
    checks++;
    if (wd_q.size() - base != 4) begin
      fails++;
      $display("FAIL overflow_writes: got %0d writes required 4", wd_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wa_q[base+i] !== 2'(i) || wd_q[base+i] !== exp_words[i]) begin
          fails++;
          $display("FAIL overflow_word%0d: %h@%0d required %h@%0d", i, wd_q[base+i], wa_q[base+i], exp_words[i], i);
        end
      end
    end
    for (int i = 16; i < 20; i++) begin
      load_valid = 1'b1;
      load_byte  = 8'(i + 1);
      #1;
      checks++;
      if (load_ready !== 1'b0) begin
        fails++;
        $display("FAIL overflow_ready: byte %0d ready=%b required 0", i, load_ready);
      end
      step();
    end
    load_valid = 1'b0;
    checks++;
    if (wd_q.size() - base != 4 || load_overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky: writes=%0d ovf=%b required 4 1", wd_q.size() - base, load_overflow);
    end
  endtask

  task automatic test_restart();
    int base;
    pulse_start();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    base = wd_q.size();
    load_start = 1'b1;
    load_valid = 1'b1;
    load_byte  = 8'h99;
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
    checks++;
    if (wd_q.size() != base || load_word_count !== '0 || load_ready !== 1'b1) begin
      fails++;
      $display("FAIL restart_clear: writes=%0d cnt=%0d ready=%b required 0 0 1",
               wd_q.size() - base, load_word_count, load_ready);
    end
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b1);
    wait_run();
    step();
    checks++;
    if (wd_q.size() - base != 1) begin
      fails++;
      $display("FAIL restart_writes: got %0d writes required 1", wd_q.size() - base);
    end else begin
      checks++;
      if (wd_q[base] !== 32'h3344_5566 || wa_q[base] !== 2'd0) begin
        fails++;
        $display("FAIL restart_data: %h@%0d required 33445566@0", wd_q[base], wa_q[base]);
      end
    end
    load_start = 1'b1;
    #1;
    checks++;
    if (cpu_run !== 1'b1) begin
      fails++;
      $display("FAIL run_before_start: run=%b required 1", cpu_run);
    end
    step();
    load_start = 1'b0;
    checks++;
    if (cpu_run !== 1'b0 || fetch_valid !== 1'b0 || load_ready !== 1'b1) begin
      fails++;
      $display("FAIL run_after_start: run=%b fv=%b ready=%b required 0 0 1", cpu_run, fetch_valid, load_ready);
    end
  endtask

  task automatic test_reset_in_write();
    int base;
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hC4, 1'b0);
    checks++;
    if (mem_write_enable !== 1'b1) begin
      fails++;
      $display("FAIL write_cycle_strobe: we=%b required 1", mem_write_enable);
    end
    base = wd_q.size();
    reset = 1'b1;
    #1;
    checks++;
    if ({load_ready, load_done, load_overflow, cpu_run, fetch_valid, mem_write_enable} !== 6'b0 ||
        mem_address !== '0 || mem_write_data !== '0 || load_word_count !== '0 || load_checksum !== '0) begin
      fails++;
      $display("FAIL reset_in_write: ctl=%b addr=%h data=%h cnt=%0d sum=%h required all 0",
               {load_ready, load_done, load_overflow, cpu_run, fetch_valid, mem_write_enable},
               mem_address, mem_write_data, load_word_count, load_checksum);
    end
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (wd_q.size() != base || load_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_write_nowrite: writes=%0d ready=%b required 0 0", wd_q.size() - base, load_ready);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_fetch();
    test_partial_word();
    test_overflow();
    test_restart();
    test_reset_in_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
